// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register-address width, the zero register and
// the hazard controller state encoding.
package mips_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned MD_CNT_W   = 6;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      IDLE,
      MD_BUSY
   } hz_state_e;

endpackage

// File: rtl/muldiv_busy_timer.sv
// Occupancy timer for the HI/LO unit: loads MULDIV_CYCLES-1 on issue and counts
// down, holding busy high for exactly MULDIV_CYCLES cycles after the issue cycle.
module muldiv_busy_timer
   import mips_pkg::*;
#(
   parameter int unsigned MULDIV_CYCLES = 32
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   output logic busy
);

   localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MULDIV_CYCLES - 1);

   hz_state_e             state_q;
   logic [MD_CNT_W-1:0]   md_cnt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         md_cnt_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q  <= MD_BUSY;
                  md_cnt_q <= MD_LOAD;
               end
            end
            MD_BUSY: begin
               if (md_cnt_q == '0) begin
                  // Issue cannot overlap the window: the top holds MULT/DIV while busy.
                  if (start) begin
                     md_cnt_q <= MD_LOAD;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  md_cnt_q <= md_cnt_q - 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               md_cnt_q <= '0;
            end
         endcase
      end
   end

   assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// IF/ID stall/flush and ID/EX bubble control: load-use, branch redirect and
// HI/LO busy interlocks. Optional HAZARD_STATS_EN adds stall/flush counters.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned MULDIV_CYCLES = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  id_reads_hilo,
   input  logic                  id_muldiv,
   input  logic                  idex_memread,
   input  logic [REG_ADDR_W-1:0] idex_rt,
   input  logic                  branch_taken,
   output logic                  pc_write,
   output logic                  ifid_stall,
   output logic                  ifid_flush,
   output logic                  idex_bubble,
   output logic                  muldiv_busy
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]           stall_count,
   output logic [31:0]           flush_count
`endif
);

   logic load_use;
   logic md_hold;
   logic hold;
   logic md_issue;

   assign load_use = idex_memread && (idex_rt != REG_ZERO) &&
                     ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
   assign md_hold  = muldiv_busy && (id_reads_hilo || id_muldiv);
   assign hold     = load_use || md_hold;
   assign md_issue = id_muldiv && !hold && !branch_taken;

   muldiv_busy_timer #(
      .MULDIV_CYCLES (MULDIV_CYCLES)
   ) u_timer (
      .clock (clock),
      .reset (reset),
      .start (md_issue),
      .busy  (muldiv_busy)
   );

   // A held branch has stale operands, so it is ignored and re-presented later.
   always_comb begin
      pc_write    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (reset) begin
         if (hold) begin
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
         end else begin
            pc_write   = 1'b1;
            ifid_flush = branch_taken;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (ifid_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the stall/flush side of the IF/ID pipeline register and the bubble control of ID/EX in the 5-stage MIPS core. It detects load-use hazards, resolves branch/jump redirects into IF/ID flushes, and sequences a multi-cycle MULT/DIV busy window during which dependent HI/LO reads are held in ID. It is the producer of the `stall`/`flush` handshake that the IF/ID register consumes; PC update is gated by the same decision.

## Interface
- `MULDIV_CYCLES`, 32: cycles a MULT/DIV occupies the HI/LO unit (legal 2..63).
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `id_rs` in 5: rs field of instruction in ID.
- `id_rt` in 5: rt field of instruction in ID.
- `id_uses_rt` in 1: ID instruction reads rt as a source.
- `id_reads_hilo` in 1: ID instruction is MFHI/MFLO.
- `id_muldiv` in 1: ID instruction is MULT/MULTU/DIV/DIVU.
- `idex_memread` in 1: instruction in EX is a load.
- `idex_rt` in 5: destination rt of instruction in EX.
- `branch_taken` in 1: ID-resolved branch/jump redirect this cycle.
- `pc_write` out 1: enable PC update.
- `ifid_stall` out 1: hold IF/ID contents.
- `ifid_flush` out 1: zero IF/ID instruction.
- `idex_bubble` out 1: load NOP into ID/EX.
- `muldiv_busy` out 1: HI/LO unit occupied.

## Operation
- States: IDLE, MD_BUSY. Down-counter `md_cnt` (6 bits).
- load_use = idex_memread & (idex_rt != 0) & ((idex_rt == id_rs) | (id_uses_rt & idex_rt == id_rt)).
- md_hold = MD_BUSY & (id_reads_hilo | id_muldiv).
- hold = load_use | md_hold.
- hold: pc_write=0, ifid_stall=1, ifid_flush=0, idex_bubble=1. branch_taken ignored (branch operands not yet valid).
- branch_taken & ~hold: pc_write=1, ifid_stall=0, ifid_flush=1, idex_bubble=0.
- Otherwise: pc_write=1, all others 0.
- Flush and stall never both 1.
- IDLE -> MD_BUSY when id_muldiv & ~hold & ~branch_taken-squash (MULT in ID advances); md_cnt <= MULDIV_CYCLES-1.
- MD_BUSY: md_cnt decrements each cycle; at md_cnt==0 -> IDLE. A held MULT/DIV in ID issues the cycle the unit returns to IDLE (state goes straight back to MD_BUSY, counter reloaded).
- muldiv_busy = (state == MD_BUSY).

## Timing
- All outputs combinational from inputs plus registered state; zero-cycle latency.
- Reset (reset low, any time): state=IDLE, md_cnt=0; outputs pc_write=0, ifid_stall=0, ifid_flush=0, idex_bubble=0, muldiv_busy=0; counters cleared. Reset mid-MD_BUSY aborts the window.
- Load-use stall lasts exactly 1 cycle (bubble moves load to MEM).
- MULT issued in cycle N: muldiv_busy high cycles N+1..N+MULDIV_CYCLES; MFHI in ID released in cycle N+MULDIV_CYCLES+1.
- branch_taken with load_use in same cycle: stall wins; branch re-presented next cycle and flushes then.

## Configuration
- `HAZARD_STATS_EN` defined: adds outputs `stall_count` out 32 and `flush_count` out 32; increment on each cycle ifid_stall / ifid_flush is 1; saturate at 0xFFFFFFFF; cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared `mips_pkg`: `REG_ADDR_W=5`, hazard state enum (IDLE, MD_BUSY), `REG_ZERO=5'd0`.
- One sub-module `muldiv_busy_timer`: load/decrement counter and busy flag, parameterised by MULDIV_CYCLES.

## Test plan
- LW $t0 in EX (idex_memread=1, idex_rt=8), ADD using rs=8 in ID -> one cycle pc_write=0, ifid_stall=1, idex_bubble=1; next cycle all clear.
- idex_rt=0 with idex_memread=1, id_rs=0 -> no stall.
- branch_taken=1, no hazard -> ifid_flush=1, pc_write=1, ifid_stall=0 for one cycle.
- branch_taken=1 and load_use same cycle -> ifid_stall=1, ifid_flush=0; next cycle branch_taken=1 -> flush.
- MULDIV_CYCLES=4: MULT in ID at cycle 0, MFLO in ID from cycle 1 -> stalled cycles 1..4, released cycle 5; back-to-back DIV also held until unit idle.
- Assert reset low during MD_BUSY -> all outputs 0 immediately, state IDLE after release; with HAZARD_STATS_EN, counters read 0.
